// File: rtl/inner_wb_burst_splitter_pkg.sv
// Shared definitions for the inner wishbone burst splitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, the burst-length ceiling, the default
// word-address width, and a helper that maps burst flags to the
// index of the last beat.
package inner_wb_burst_splitter_pkg;

    // Default wishbone word-address width, matching the bus configuration.
    localparam int WB_ADDR_W = 24;

    // Longest burst the cores issue (cache line of 8 words).
    localparam int BURST_MAX = 8;

    // Enough bits to hold BURST_MAX-1 remaining beats.
    localparam int BEAT_CNT_W = $clog2(BURST_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Remaining-beats value loaded at capture (beat count minus one).
    // The 8-beat flag wins when both flags are set.
    function automatic logic [BEAT_CNT_W-1:0] last_beat_idx(
        input logic burst_4,
        input logic burst_8
    );
        if (burst_8) begin
            return BEAT_CNT_W'(BURST_MAX - 1);
        end else if (burst_4) begin
            return BEAT_CNT_W'(3);
        end else begin
            return '0;
        end
    endfunction

endpackage

// File: rtl/inner_wb_burst_splitter.sv
// Splits 4/8-beat cache bursts into single wishbone transfers at incrementing addresses.
// Latency: request sampled at T0 -> d_stb at T1 -> u_ack/u_i_dat at T2 (zero-wait slave); 2 cycles per beat.
// Backpressure: one transfer outstanding; a beat waits on d_ack/d_err, bounded by a TIMEOUT_CYC watchdog.
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   u_cyc/u_stb/u_we/u_adr/u_sel   upstream request (address held for the whole burst)
//   u_o_dat                        upstream write data, advanced by upstream after each u_ack
//   u_4_burst/u_8_burst            burst length flags, sampled when the request is captured
//   u_i_dat/u_ack/u_err            registered read data, per-beat ack pulse, terminating error pulse
//   d_cyc/d_stb/d_we/d_adr/d_sel   downstream request (decoded from the state register)
//   d_o_dat                        downstream write data, combinational pass-through of u_o_dat
//   d_i_dat/d_ack/d_err            downstream response
module inner_wb_burst_splitter
    import inner_wb_burst_splitter_pkg::*;
#(
    parameter int ADDR_W      = WB_ADDR_W,
    parameter int DATA_W      = 16,
    parameter int SEL_W       = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,

    input  logic              u_cyc,
    input  logic              u_stb,
    input  logic              u_we,
    input  logic [ADDR_W-1:0] u_adr,
    input  logic [DATA_W-1:0] u_o_dat,
    input  logic [SEL_W-1:0]  u_sel,
    input  logic              u_4_burst,
    input  logic              u_8_burst,
    output logic [DATA_W-1:0] u_i_dat,
    output logic              u_ack,
    output logic              u_err,

    output logic              d_cyc,
    output logic              d_stb,
    output logic              d_we,
    output logic [ADDR_W-1:0] d_adr,
    output logic [SEL_W-1:0]  d_sel,
    output logic [DATA_W-1:0] d_o_dat,
    input  logic [DATA_W-1:0] d_i_dat,
    input  logic              d_ack,
    input  logic              d_err
);

    // Watchdog limit in counter width (counter is 8 bits).
    localparam logic [7:0] TMO_LIM = 8'(TIMEOUT_CYC);

    state_t                state_q,    state_d;
    logic [ADDR_W-1:0]     adr_q,      adr_d;
    logic                  we_q,       we_d;
    logic [SEL_W-1:0]      sel_q,      sel_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [7:0]            tmo_q,      tmo_d;
    logic                  ack_q,      ack_d;
    logic                  err_q,      err_d;
    logic [DATA_W-1:0]     rdat_q,     rdat_d;
    // Set for the single IDLE cycle following a finished burst, so the
    // upstream request still asserted while it observes u_ack/u_err is
    // not mistaken for a new one.
    logic                  hold_q,     hold_d;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        beat_cnt_d = beat_cnt_q;
        tmo_d      = tmo_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdat_d     = rdat_q;
        hold_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (u_cyc && u_stb && !hold_q) begin
                    adr_d      = u_adr;
                    we_d       = u_we;
                    sel_d      = u_sel;
                    beat_cnt_d = last_beat_idx(u_4_burst, u_8_burst);
                    state_d    = ST_BEAT;
                end
            end

            ST_BEAT: begin
                tmo_d = tmo_q + 8'd1;
                if (d_err) begin
                    // Error (alone or alongside ack) ends the whole burst.
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (d_ack) begin
                    // An upstream that already dropped u_cyc gets no ack;
                    // the beat is allowed to finish on the bus regardless.
                    if (u_cyc) begin
                        ack_d  = 1'b1;
                        rdat_d = d_i_dat;
                    end
                    if ((beat_cnt_q != '0) && u_cyc) begin
                        state_d = ST_GAP;
                    end else begin
                        hold_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == TMO_LIM) begin
                    err_d   = 1'b1;
                    hold_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_GAP: begin
                // Address wraps naturally at ADDR_W bits.
                adr_d      = adr_q + ADDR_W'(1);
                beat_cnt_d = beat_cnt_q - BEAT_CNT_W'(1);
                tmo_d      = '0;
                state_d    = u_cyc ? ST_BEAT : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            beat_cnt_q <= '0;
            tmo_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            beat_cnt_q <= beat_cnt_d;
            tmo_q      <= tmo_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
            hold_q     <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Bus strobes decode straight from the state register so that reset
    // removes them asynchronously.
    assign d_cyc   = (state_q != ST_IDLE);
    assign d_stb   = (state_q == ST_BEAT);
    assign d_we    = we_q;
    assign d_adr   = adr_q;
    assign d_sel   = sel_q;
    assign d_o_dat = u_o_dat;

    assign u_ack   = ack_q;
    assign u_err   = err_q;
    assign u_i_dat = rdat_q;

endmodule
